// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: default widths, the NOP word and the loader state encoding
// shared by the loader and its tests.
package instruction_loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_INSTR_W = 9;
    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_WORD = 9'h000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_e;

endpackage

// File: rtl/instruction_loader_store.sv
// instruction_store: program memory with one synchronous write port and one
// asynchronous read port; no reset, contents survive control resets.
module instruction_store #(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: valid/ready program loader feeding a single-cycle fetch port.
// Define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the last word.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Load_Start,
    input  logic               Load_Valid,
    input  logic [INSTR_W-1:0] Load_Data,
    input  logic               Load_Last,
    output logic               Load_Ready,
    input  logic [ADDR_W-1:0]  Adress_Instruction_Bus,
    output logic [INSTR_W-1:0] Instruction,
    output logic               Core_Hold,
    output logic               Load_Error,
    output logic [ADDR_W:0]    Words_Loaded
);

    state_e state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic err_q, err_d, ready_q, hold_q, xfer, we;
    logic [INSTR_W-1:0] rdata;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] csum_q, csum_d;
`endif

    assign xfer = Load_Valid && ready_q;

    // The low count bits double as the write pointer; the top bit marks a full store.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d = err_q;
        we = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum_d = csum_q;
`endif
        if (Load_Start) begin
            state_d = LOAD;
            count_d = '0;
            err_d = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_d = '0;
`endif
        end else if (state_q == IDLE) begin
            count_d = '0;
            err_d = 1'b0;
        end else if (state_q == LOAD && xfer) begin
            if (count_q[ADDR_W]) begin
                state_d = ERROR;
                err_d = 1'b1;
            end else begin
                we = 1'b1;
                count_d = count_q + (ADDR_W+1)'(1);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ Load_Data;
                if (Load_Last) state_d = CHECK;
`else
                if (Load_Last) state_d = RUN;
`endif
            end
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        else if (state_q == CHECK && xfer) begin
            state_d = (Load_Data == csum_q) ? RUN : ERROR;
            err_d = Load_Data != csum_q;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q <= 1'b0;
            ready_q <= 1'b0;
            hold_q <= 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q <= err_d;
            ready_q <= state_d == LOAD || state_d == CHECK;
            hold_q <= state_d != RUN;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    instruction_store #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_store (
        .clk  (Clk),
        .we   (we),
        .waddr(count_q[ADDR_W-1:0]),
        .wdata(Load_Data),
        .raddr(Adress_Instruction_Bus),
        .rdata(rdata)
    );

    assign Load_Ready = ready_q;
    assign Core_Hold = hold_q;
    assign Load_Error = err_q;
    assign Words_Loaded = count_q;
    assign Instruction = hold_q ? NOP_WORD : rdata;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized load/fetch scenarios checked against a behavioural
// program-store model; checksum scenarios run when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic Clk = 1'b0, Reset = 1'b0, Load_Start = 1'b0, Load_Valid = 1'b0, Load_Last = 1'b0;
    logic [8:0] Load_Data = '0;
    logic [7:0] Adress_Instruction_Bus = '0;
    logic Load_Ready, Core_Hold, Load_Error;
    logic [8:0] Instruction, Words_Loaded;

    int checks = 0, errors = 0;

    logic [8:0] m_mem [256];
    bit m_wr [256];
    int m_cnt = 0;
    bit m_load = 0, m_run = 0, m_err = 0, m_chk = 0;
    logic [8:0] m_x = '0;

    always #5 Clk = ~Clk;

    instruction_loader dut (
        .Clk(Clk), .Reset(Reset), .Load_Start(Load_Start), .Load_Valid(Load_Valid),
        .Load_Data(Load_Data), .Load_Last(Load_Last), .Load_Ready(Load_Ready),
        .Adress_Instruction_Bus(Adress_Instruction_Bus), .Instruction(Instruction),
        .Core_Hold(Core_Hold), .Load_Error(Load_Error), .Words_Loaded(Words_Loaded)
    );

    // Advance the model by one clock using the currently driven inputs, then the DUT.
    task automatic step();
        if (Load_Start) begin
            m_load = 1; m_run = 0; m_err = 0; m_chk = 0; m_cnt = 0; m_x = '0;
        end else if (m_chk && Load_Valid) begin
            m_chk = 0;
            if (Load_Data == m_x) m_run = 1; else m_err = 1;
        end else if (m_load && Load_Valid) begin
            if (m_cnt == 256) begin
                m_load = 0; m_err = 1;
            end else begin
                m_mem[m_cnt] = Load_Data; m_wr[m_cnt] = 1; m_x ^= Load_Data; m_cnt++;
                if (Load_Last) begin
                    m_load = 0;
                    if (CSUM) m_chk = 1; else m_run = 1;
                end
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic start();
        Load_Start = 1; step(); Load_Start = 0;
    endtask

    task automatic send(input logic [8:0] d, input bit last);
        Load_Valid = 1; Load_Data = d; Load_Last = last; step();
        Load_Valid = 0; Load_Last = 0;
    endtask

    task automatic finish_load();
        if (CSUM) send(m_x, 0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1 Reset = 1; #1;
        checks++; if (Core_Hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", Core_Hold); end
        checks++; if (Instruction !== 9'h000) begin errors++; $display("FAIL reset_instr: got %h want 000", Instruction); end
        checks++; if (Load_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", Load_Ready); end
        checks++; if (Load_Error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", Load_Error); end
        checks++; if (Words_Loaded !== 9'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", Words_Loaded); end
        @(posedge Clk); #1;
    endtask

    task automatic test_basic();
        start();
        checks++; if (Load_Ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", Load_Ready); end
        send(9'h101, 0); send(9'h0A2, 0);
        checks++; if (Core_Hold !== 1'b1) begin errors++; $display("FAIL basic_hold_loading: got %b want 1", Core_Hold); end
        send(9'h1FF, 1);
        finish_load();
        checks++; if (Words_Loaded !== 9'd3) begin errors++; $display("FAIL basic_words: got %0d want 3", Words_Loaded); end
        checks++; if (Core_Hold !== 1'b0) begin errors++; $display("FAIL basic_hold_run: got %b want 0", Core_Hold); end
        checks++; if (Load_Ready !== 1'b0) begin errors++; $display("FAIL basic_ready_run: got %b want 0", Load_Ready); end
        for (int a = 0; a < 3; a++) begin
            logic [8:0] exp;
            exp = (a == 0) ? 9'h101 : (a == 1) ? 9'h0A2 : 9'h1FF;
            Adress_Instruction_Bus = 8'(a); #1;
            checks++; if (Instruction !== exp) begin errors++; $display("FAIL basic_fetch[%0d]: got %h want %h", a, Instruction, exp); end
        end
    endtask

    task automatic test_gaps();
        bit pat [5] = '{1, 0, 0, 1, 1};
        start();
        for (int i = 0; i < 5; i++) begin
            checks++; if (Load_Ready !== 1'b1) begin errors++; $display("FAIL gaps_ready[%0d]: got %b want 1", i, Load_Ready); end
            Load_Valid = pat[i]; Load_Data = 9'($urandom); Load_Last = (i == 4);
            step();
        end
        Load_Valid = 0; Load_Last = 0;
        finish_load();
        checks++; if (Words_Loaded !== 9'd3) begin errors++; $display("FAIL gaps_words: got %0d want 3", Words_Loaded); end
        for (int a = 0; a < 3; a++) begin
            Adress_Instruction_Bus = 8'(a); #1;
            checks++; if (Instruction !== m_mem[a]) begin errors++; $display("FAIL gaps_fetch[%0d]: got %h want %h", a, Instruction, m_mem[a]); end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] w0;
        start();
        for (int i = 0; i < 256; i++) send(9'($urandom), 0);
        checks++; if (Words_Loaded !== 9'd256) begin errors++; $display("FAIL ovf_words_full: got %0d want 256", Words_Loaded); end
        checks++; if (Load_Error !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", Load_Error); end
        w0 = m_mem[0];
        send(~w0, 0);
        checks++; if (Load_Error !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", Load_Error); end
        checks++; if (Core_Hold !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", Core_Hold); end
        checks++; if (Load_Ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", Load_Ready); end
        checks++; if (Instruction !== 9'h000) begin errors++; $display("FAIL ovf_nop: got %h want 000", Instruction); end
        checks++; if (dut.u_store.mem[0] !== w0) begin errors++; $display("FAIL ovf_store0: got %h want %h", dut.u_store.mem[0], w0); end
        repeat (3) step();
        checks++; if (Load_Error !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b want 1", Load_Error); end
    endtask

    task automatic test_reload();
        logic [8:0] d;
        start();
        checks++; if (Load_Error !== 1'b0) begin errors++; $display("FAIL reload_err: got %b want 0", Load_Error); end
        checks++; if (Load_Ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b want 1", Load_Ready); end
        checks++; if (Words_Loaded !== 9'd0) begin errors++; $display("FAIL reload_words: got %0d want 0", Words_Loaded); end
        send(9'($urandom), 0); send(9'($urandom), 0);
        Load_Start = 1; Load_Valid = 1; Load_Data = 9'h155; step();
        Load_Start = 0; Load_Valid = 0;
        checks++; if (Words_Loaded !== 9'd0) begin errors++; $display("FAIL restart_words: got %0d want 0", Words_Loaded); end
        d = 9'h0AA;
        send(d, 1);
        finish_load();
        checks++; if (Words_Loaded !== 9'd1) begin errors++; $display("FAIL restart_words1: got %0d want 1", Words_Loaded); end
        Adress_Instruction_Bus = 8'd0; #1;
        checks++; if (Instruction !== d) begin errors++; $display("FAIL restart_fetch0: got %h want %h", Instruction, d); end
    endtask

    task automatic test_reset_midload();
        start();
        send(9'($urandom), 0); send(9'($urandom), 0);
        Reset = 0; #1;
        m_load = 0; m_run = 0; m_err = 0; m_chk = 0; m_cnt = 0;
        checks++; if (Core_Hold !== 1'b1) begin errors++; $display("FAIL rstmid_hold: got %b want 1", Core_Hold); end
        checks++; if (Load_Ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", Load_Ready); end
        checks++; if (Words_Loaded !== 9'd0) begin errors++; $display("FAIL rstmid_words: got %0d want 0", Words_Loaded); end
        #2 Reset = 1;
        step();
        start();
        send(9'($urandom), 1);
        finish_load();
        checks++; if (Words_Loaded !== 9'd1) begin errors++; $display("FAIL rstmid_words1: got %0d want 1", Words_Loaded); end
        checks++; if (Core_Hold !== 1'b0) begin errors++; $display("FAIL rstmid_run: got %b want 0", Core_Hold); end
        for (int a = 0; a < 2; a++) begin
            Adress_Instruction_Bus = 8'(a); #1;
            checks++; if (Instruction !== m_mem[a]) begin errors++; $display("FAIL rstmid_fetch[%0d]: got %h want %h", a, Instruction, m_mem[a]); end
        end
    endtask

    task automatic test_random_programs();
        for (int it = 0; it < 8; it++) begin
            int len;
            len = int'($urandom_range(1, 24));
            start();
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    checks++; if (Load_Ready !== 1'b1) begin errors++; $display("FAIL rand_ready: got %b want 1", Load_Ready); end
                    step();
                end
                send(9'($urandom), i == len - 1);
            end
            finish_load();
            checks++; if (Words_Loaded !== 9'(m_cnt)) begin errors++; $display("FAIL rand_words: got %0d want %0d", Words_Loaded, m_cnt); end
            checks++; if (Core_Hold !== !m_run) begin errors++; $display("FAIL rand_hold: got %b want %b", Core_Hold, !m_run); end
            repeat (6) begin
                int a;
                a = int'($urandom_range(0, len - 1));
                Adress_Instruction_Bus = 8'(a); #1;
                checks++; if (Instruction !== m_mem[a]) begin errors++; $display("FAIL rand_fetch[%0d]: got %h want %h", a, Instruction, m_mem[a]); end
            end
        end
        for (int a = 0; a < 256; a++) begin
            if (m_wr[a]) begin
                Adress_Instruction_Bus = 8'(a); #1;
                checks++; if (Instruction !== m_mem[a]) begin errors++; $display("FAIL sweep_fetch[%0d]: got %h want %h", a, Instruction, m_mem[a]); end
            end
        end
    endtask

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        start();
        send(9'h003, 0); send(9'h005, 1);
        checks++; if (Core_Hold !== 1'b1) begin errors++; $display("FAIL csum_hold_check: got %b want 1", Core_Hold); end
        checks++; if (Load_Ready !== 1'b1) begin errors++; $display("FAIL csum_ready_check: got %b want 1", Load_Ready); end
        send(9'h006, 0);
        checks++; if (Core_Hold !== 1'b0) begin errors++; $display("FAIL csum_match_run: got %b want 0", Core_Hold); end
        checks++; if (Words_Loaded !== 9'd2) begin errors++; $display("FAIL csum_words: got %0d want 2", Words_Loaded); end
        start();
        send(9'h003, 0); send(9'h005, 1); send(9'h007, 0);
        checks++; if (Load_Error !== 1'b1) begin errors++; $display("FAIL csum_mismatch_err: got %b want 1", Load_Error); end
        checks++; if (Core_Hold !== 1'b1) begin errors++; $display("FAIL csum_mismatch_hold: got %b want 1", Core_Hold); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_reload();
        test_reset_midload();
        test_random_programs();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
